// File: rtl/cla_serial_subtractor.sv
// Multi-cycle N-bit subtractor D = A - B - Bin, one G-bit borrow-lookahead group per clock.
// Latency: start accepted on edge 0, done pulses in the cycle after edge N/G+1.
// Backpressure: start is ignored while busy=1; the result holds until the next completion.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   start, A, B, Bin    request pulse and operands, sampled on the accepting edge
//   busy, done          operation in progress / single-cycle result-valid pulse
//   D, Bout, V          difference, unsigned borrow out, signed overflow
module cla_serial_subtractor #(
   parameter int N = 16,
   parameter int G = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Bin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] D,
   output logic         Bout,
   output logic         V
);

   localparam int NG = N / G;
   localparam int CW = (NG > 1) ? $clog2(NG) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [N-1:0]  a_q;
   logic [N-1:0]  b_q;
   logic [N-1:0]  res_q;
   logic          borrow_q;

   int unsigned   base;
   logic [G-1:0]  ga;
   logic [G-1:0]  gb;
   logic [G-1:0]  gg;
   logic [G-1:0]  gp;
   logic [G:0]    gc;
   logic [G-1:0]  gd;

   // Group slice: subtraction as A + ~B + ~borrow. Every internal carry is the
   // fully expanded generate/propagate sum-of-products, so no carry depends
   // on another carry inside the slice.
   always_comb begin
      logic acc;
      logic term;
      base = 32'(cnt) * 32'(G);
      ga   = a_q[base +: G];
      gb   = ~b_q[base +: G];
      gg   = ga & gb;
      gp   = ga ^ gb;
      gc   = '0;
      gc[0] = ~borrow_q;
      for (int i = 0; i < G; i++) begin
         // carry-in term propagated through bits 0..i
         acc = gc[0];
         for (int k = 0; k <= i; k++) acc = acc & gp[k];
         // generate at bit j propagated through bits j+1..i
         for (int j = 0; j <= i; j++) begin
            term = gg[j];
            for (int k = j + 1; k <= i; k++) term = term & gp[k];
            acc = acc | term;
         end
         gc[i+1] = acc;
      end
      gd = gp ^ gc[G-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         D        <= '0;
         Bout     <= 1'b0;
         V        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_q      <= A;
                  b_q      <= B;
                  borrow_q <= Bin;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= S_CALC;
               end
            end
            S_CALC: begin
               res_q[base +: G] <= gd;
               // borrow is the complement of the slice carry-out
               borrow_q <= ~gc[G];
               if (cnt == CW'(NG - 1)) begin
                  cnt   <= '0;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               // outputs only update here, so partial results are never visible
               D     <= res_q;
               Bout  <= borrow_q;
               V     <= (a_q[N-1] ^ b_q[N-1]) & (res_q[N-1] ^ a_q[N-1]);
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_serial_subtractor.sv
module tb_cla_serial_subtractor;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        Bin;
   logic        busy;
   logic        done;
   logic [15:0] D;
   logic        Bout;
   logic        V;

   int checks;
   int failures;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] d;
      logic        bout;
      logic        v;
   } vec_t;

   vec_t sb[$];
   vec_t vecs[10];

   cla_serial_subtractor #(.N(16), .G(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .Bout  (Bout),
      .V     (V)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            vec_t e;
            e = sb.pop_front();
            chk("D", 32'(D), 32'(e.d));
            chk("Bout", 32'(Bout), 32'(e.bout));
            chk("V", 32'(V), 32'(e.v));
         end
      end
   end

   // Call at #1 after a posedge; returns edges elapsed until done is seen (0 = timeout).
   task automatic wait_done(output int lat, output int busy_cycles);
      lat = 0;
      busy_cycles = 0;
      for (int i = 1; i <= 20; i++) begin
         if (busy) busy_cycles++;
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   function automatic vec_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
      vec_t r;
      logic [16:0] full;
      full   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
      r.a    = a;
      r.b    = b;
      r.bin  = bin;
      r.d    = full[15:0];
      r.bout = full[16];
      r.v    = (a[15] != b[15]) && (full[15] != a[15]);
      return r;
   endfunction

   task automatic run_op(input vec_t v);
      int lat;
      int bc;
      start = 1'b1; A = v.a; B = v.b; Bin = v.bin;
      sb.push_back(v);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat, bc);
      chk("latency", 32'(lat), 32'd5);
      chk("busy_cycles", 32'(bc), 32'd5);
      chk("busy_at_done", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("done_single", 32'(done), 32'd0);
      chk("D_hold", 32'(D), 32'(v.d));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int bc;
      checks   = 0;
      failures = 0;

      vecs[0] = '{16'd3,    16'd2,    1'b0, 16'd1,    1'b0, 1'b0};
      vecs[1] = '{16'd5,    16'd4,    1'b1, 16'd0,    1'b0, 1'b0};
      vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
      vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
      vecs[6] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
      vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[8] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[9] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};

      rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_D", 32'(D), 32'd0);
      chk("rst_Bout", 32'(Bout), 32'd0);
      chk("rst_V", 32'(V), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) run_op(vecs[i]);

      for (int i = 0; i < 6; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_op(model(ra, rb, 1'($urandom_range(1))));
      end

      // start while busy is ignored; back-to-back start in the done cycle is accepted
      start = 1'b1; A = 16'd9; B = 16'd4; Bin = 1'b0;
      sb.push_back(model(16'd9, 16'd4, 1'b0));
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; A = 16'd1; B = 16'd1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat, bc);
      chk("ignore_latency", 32'(lat), 32'd3);
      chk("ignore_D", 32'(D), 32'd5);
      start = 1'b1; A = 16'd100; B = 16'd1; Bin = 1'b0;
      sb.push_back(model(16'd100, 16'd1, 1'b0));
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_D_held", 32'(D), 32'd5);
      wait_done(lat, bc);
      chk("b2b_latency", 32'(lat), 32'd5);
      chk("b2b_D", 32'(D), 32'd99);
      @(posedge clk); #1;

      // reset sampled on edge 3 of an operation aborts it without a done pulse
      start = 1'b1; A = 16'h1234; B = 16'h0034; Bin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_D", 32'(D), 32'd0);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done), 32'd0);
      run_op(vecs[6]);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cla_serial_subtractor.md
Name: cla_serial_subtractor

Overview:
Multi-cycle N-bit subtractor computing D = A - B - Bin. It processes one G-bit group per clock using a G-bit borrow-lookahead slice (A + ~B + ~borrow). The group borrow ripples between cycles through a register. It is the subtraction counterpart of the team's CLA adder and is used where area matters more than single-cycle latency. Operation is controlled by a start/done handshake.

Parameters:
N, 16, operand and result width in bits; must be a multiple of G.
G, 4, group width processed per clock by the lookahead slice.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
start  input  1  request pulse; sampled only when busy=0.
A  input  N  minuend; sampled on the edge that accepts start.
B  input  N  subtrahend; sampled on the edge that accepts start.
Bin  input  1  borrow in; sampled on the edge that accepts start.
busy  output  1  high while an operation is in progress.
done  output  1  single-cycle pulse; result valid.
D  output  N  difference, A - B - Bin mod 2^N.
Bout  output  1  borrow out; 1 iff A < B + Bin (unsigned).
V  output  1  signed overflow: (A[N-1]!=B[N-1]) && (D[N-1]!=A[N-1]).

Behaviour:
- Reset: all of these are sampled on the clk edge while rst_n=0, and all take effect that edge.
  - busy=0, done=0, D=0, Bout=0, V=0.
  - FSM returns to IDLE; group counter=0; internal operand and borrow registers=0.
  - A reset mid-operation aborts the operation. No done pulse is produced for it.
- FSM states: IDLE, CALC, DONE.
  - IDLE: on start=1, latch A, B and Bin (internal borrow register = Bin), set counter=0, set busy=1, go to CALC.
  - CALC: each edge computes group k = bits [k*G+G-1 : k*G].
    - Diff bits = A_k + ~B_k + ~borrow.
    - Next borrow = inverted carry-out of the slice.
    - Diff bits are written to the internal result register; counter increments.
    - After group N/G-1 is processed, go to DONE.
  - DONE: on one edge, drive D from the result register and Bout from the final borrow. Compute V. Set done=1 for exactly one cycle and busy=0. Go to IDLE.
- Slice: generate/propagate lookahead within the G-bit slice; no ripple inside the slice.
- Latency: the edge that accepts start is edge 0. done is high in the cycle following edge N/G+1. For N=16, G=4 that is 5 edges after acceptance.
- start while busy=1 is ignored. The in-flight operands are unaffected.
- start in the cycle where done=1 is accepted (busy=0 there). The next operation begins and the current D stays valid until that operation completes.
- D, Bout and V hold their last values until the next completion or reset. They never show partial results.
- Width rule: D wraps modulo 2^N.
- Bin=1 with A=B gives D = all-ones and Bout=1.

Test Plan:
- Reset, then A=3, B=2, Bin=0, start pulse -> done exactly 5 edges later; D=16'd1, Bout=0, V=0; busy high for 5 cycles.
- A=5, B=4, Bin=1 -> D=16'd0, Bout=0, V=0.
- A=16'h0000, B=16'h0001, Bin=0 -> D=16'hFFFF, Bout=1, V=0. Also A=16'hFFFF, B=16'hFFFF, Bin=1 -> D=16'hFFFF, Bout=1.
- A=16'h8000, B=16'h0001, Bin=0 -> D=16'h7FFF, Bout=0, V=1. Also A=16'h7FFF, B=16'hFFFF -> D=16'h8000, Bout=1, V=1.
- start with A=9, B=4; at edge 2 assert start again with A=1, B=1 -> ignored; done shows D=16'd5. A back-to-back start in the done cycle yields a second result 5 edges later.
- start with A=16'h1234, B=16'h0034; rst_n=0 at edge 3 -> busy=0, D=0, no done pulse. A new operation after reset completes with correct D=16'h1200.
